// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM duty-class encodings, decoder states and class thresholds
package pwm_pkg;

    typedef enum logic [2:0] {
        DUTY_0   = 3'd0,
        DUTY_5   = 3'd1,
        DUTY_10  = 3'd2,
        DUTY_25  = 3'd3,
        DUTY_50  = 3'd4,
        DUTY_100 = 3'd5
    } duty_code_e;

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2,
        REPORT    = 2'd3
    } dec_state_e;

    // Class boundary k means high/period < k/40, i.e. high*40 < k*period.
    localparam int unsigned HIGH_SCALE = 40;
    localparam int unsigned THR_5      = 1;
    localparam int unsigned THR_10     = 3;
    localparam int unsigned THR_25     = 7;
    localparam int unsigned THR_50     = 15;
    localparam int unsigned THR_100    = 30;

endpackage

// File: rtl/pwm_edge_sync.sv
// rtl/pwm_edge_sync.sv - two-flop synchronizer plus edge register for an asynchronous PWM input
module pwm_edge_sync (
    input  logic sysclk,
    input  logic rst,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    // [0],[1] form the synchronizer; [2] holds the previous synchronized level.
    logic [2:0] sync_q;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], pwm_in};
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];
    assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/pwm_duty_decoder.sv
// rtl/pwm_duty_decoder.sv - measures PWM period/high time and classifies the duty cycle
module pwm_duty_decoder
    import pwm_pkg::*;
#(
    parameter int CNT_W      = 20,
    parameter int MIN_PERIOD = 50000,
    parameter int MAX_PERIOD = 200000
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [2:0]       duty_code,
    output logic             duty_valid,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             err
);

    localparam int              PROD_W  = CNT_W + 6;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    dec_state_e       state_q, state_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic             level, rise, fall;
    logic             timeout;
    logic             load_report, load_timeout;
    logic [PROD_W-1:0] h_prod, p_ext;
    logic [2:0]       class_code;

    pwm_edge_sync u_edge_sync (
        .sysclk (sysclk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= MAX_CNT) ? MAX_CNT : v + ONE;
    endfunction

    always_comb begin
        h_prod = PROD_W'(hi_q) * PROD_W'(HIGH_SCALE);
        p_ext  = PROD_W'(per_q);
        if (h_prod < p_ext * PROD_W'(THR_5)) begin
            class_code = DUTY_0;
        end else if (h_prod < p_ext * PROD_W'(THR_10)) begin
            class_code = DUTY_5;
        end else if (h_prod < p_ext * PROD_W'(THR_25)) begin
            class_code = DUTY_10;
        end else if (h_prod < p_ext * PROD_W'(THR_50)) begin
            class_code = DUTY_25;
        end else if (h_prod < p_ext * PROD_W'(THR_100)) begin
            class_code = DUTY_50;
        end else begin
            class_code = DUTY_100;
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_RISE;
            per_q   <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            hi_q    <= hi_d;
        end
    end

    // REPORT counts as the first cycle of the new period, so it measures like MEAS_HIGH.
    always_comb begin
        state_d      = state_q;
        per_d        = per_q;
        hi_d         = hi_q;
        load_report  = 1'b0;
        load_timeout = 1'b0;
        timeout      = (per_q == MAX_CNT);
        case (state_q)
            WAIT_RISE: begin
                if (rise) begin
                    state_d = MEAS_HIGH;
                    per_d   = ONE;
                    hi_d    = ONE;
                end else if (timeout) begin
                    load_timeout = 1'b1;
                    per_d        = ONE;
                    hi_d         = '0;
                end else begin
                    per_d = sat_inc(per_q);
                end
            end
            MEAS_HIGH, REPORT: begin
                if (timeout) begin
                    load_timeout = 1'b1;
                    state_d      = WAIT_RISE;
                    per_d        = ONE;
                    hi_d         = '0;
                end else begin
                    per_d = sat_inc(per_q);
                    if (fall) begin
                        state_d = MEAS_LOW;
                    end else begin
                        state_d = MEAS_HIGH;
                        hi_d    = sat_inc(hi_q);
                    end
                end
            end
            MEAS_LOW: begin
                if (rise) begin
                    load_report = 1'b1;
                    state_d     = REPORT;
                    per_d       = ONE;
                    hi_d        = ONE;
                end else if (timeout) begin
                    load_timeout = 1'b1;
                    state_d      = WAIT_RISE;
                    per_d        = ONE;
                    hi_d         = '0;
                end else begin
                    per_d = sat_inc(per_q);
                end
            end
            default: begin
                state_d = WAIT_RISE;
            end
        endcase
    end

    // Report registers load on the edge into REPORT, so duty_valid is high during REPORT.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            duty_code  <= DUTY_0;
            duty_valid <= 1'b0;
            period_cnt <= '0;
            high_cnt   <= '0;
            err        <= 1'b0;
        end else begin
            duty_valid <= load_report | load_timeout;
            if (load_timeout) begin
                duty_code  <= level ? DUTY_100 : DUTY_0;
                period_cnt <= MAX_CNT;
                high_cnt   <= level ? MAX_CNT : '0;
                err        <= 1'b0;
            end else if (load_report) begin
                period_cnt <= per_q;
                high_cnt   <= hi_q;
                if (per_q < MIN_CNT) begin
                    err <= 1'b1;
                end else begin
                    err       <= 1'b0;
                    duty_code <= class_code;
                end
            end
        end
    end

endmodule
